// File: rtl/bpf16_pkg.sv
// bpf16_pkg: shared parameters and types for the BPF16 coefficient loader
package bpf16_pkg;
  localparam int N_TAPS_DEF = 16;
  localparam int COEF_W_DEF = 12;
  typedef logic signed [COEF_W_DEF-1:0] coef_t;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, PEND} coeff_ld_state_t;
endpackage

// File: rtl/coef_bank_bpf16.sv
// coef_bank_bpf16: shadow coefficient array with indexed writes and single-cycle commit to the active array
module coef_bank_bpf16 import bpf16_pkg::*; #(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int COEF_W = COEF_W_DEF,
  localparam int IW = $clog2(N_TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IW-1:0]            wr_addr,
  input  logic [COEF_W-1:0]        wr_data,
  input  logic                     commit,
  output logic [N_TAPS*COEF_W-1:0] coeff_flat
);
  logic [N_TAPS-1:0][COEF_W-1:0] shadow_q, shadow_d, active_q, active_d;
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) shadow_d[wr_addr] = wr_data;
    active_d = commit ? shadow_q : active_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end
  assign coeff_flat = active_q;
endmodule

// File: rtl/coeff_loader_bpf16.sv
// coeff_loader_bpf16: AXI-Stream coefficient frame loader with length check and safe-point commit
module coeff_loader_bpf16 import bpf16_pkg::*; #(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic signed [COEF_W-1:0] s_axis_tdata,
  input  logic                     s_axis_tlast,
  input  logic                     swap_allow,
  output logic [N_TAPS*COEF_W-1:0] coeff_flat,
  output logic                     coeff_valid,
  output logic                     coeff_update,
  output logic                     load_err
);
  localparam int IW = $clog2(N_TAPS);
  localparam logic [IW-1:0] LAST = IW'(N_TAPS - 1);
  coeff_ld_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic tready_q, tready_d, valid_q, valid_d, upd_q, upd_d, err_q, err_d;
  logic xfer, wr_en, commit;
  assign xfer = s_axis_tvalid & tready_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (xfer) begin
        err_d   = s_axis_tlast;
        wr_en   = !s_axis_tlast;
        idx_d   = s_axis_tlast ? '0 : IW'(1);
        state_d = s_axis_tlast ? IDLE : LOAD;
      end
      LOAD: if (xfer) begin
        wr_en   = 1'b1;
        idx_d   = (s_axis_tlast || idx_q == LAST) ? '0 : idx_q + 1'b1;
        err_d   = s_axis_tlast && idx_q != LAST;
        state_d = s_axis_tlast ? (idx_q == LAST ? PEND : IDLE) : (idx_q == LAST ? DRAIN : LOAD);
      end
      DRAIN: if (xfer && s_axis_tlast) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      PEND: if (swap_allow) begin
        commit  = 1'b1;
        upd_d   = 1'b1;
        valid_d = 1'b1;
        state_d = IDLE;
      end
    endcase
    // tready is registered off the next state, so PEND blocks input from its first cycle
    tready_d = state_d != PEND;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tready_q <= 1'b0;
      valid_q  <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tready_q <= tready_d;
      valid_q  <= valid_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end
  coef_bank_bpf16 #(.N_TAPS(N_TAPS), .COEF_W(COEF_W)) u_bank (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(idx_q),
    .wr_data(s_axis_tdata),
    .commit(commit),
    .coeff_flat(coeff_flat)
  );
  assign s_axis_tready = tready_q;
  assign coeff_valid   = valid_q;
  assign coeff_update  = upd_q;
  assign load_err      = err_q;
endmodule

// File: tb/tb_coeff_loader_bpf16.sv
// tb_coeff_loader_bpf16: directed self-checking bench for coeff_loader_bpf16
module tb_coeff_loader_bpf16;
  logic clk = 0, rst = 1, tv = 0, tl = 0, swap = 0;
  logic [11:0] td = 0;
  logic tready, cv, cu, le;
  logic [191:0] flat;
  int tests = 0, fails = 0, n_err = 0, n_upd = 0, accepted = 0;

  coeff_loader_bpf16 dut (
    .clk(clk), .rst(rst), .s_axis_tvalid(tv), .s_axis_tready(tready),
    .s_axis_tdata(td), .s_axis_tlast(tl), .swap_allow(swap),
    .coeff_flat(flat), .coeff_valid(cv), .coeff_update(cu), .load_err(le)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (le) n_err++;
    if (cu) n_upd++;
  end

  function automatic logic [11:0] tap(input int i);
    return flat[i*12 +: 12];
  endfunction

  task automatic send(input logic [11:0] d, input logic l);
    int n = 0;
    tv = 1; td = d; tl = l;
    while (!tready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: tready=%0b required 1", tready);
    end else accepted++;
    @(negedge clk);
    tv = 0; tl = 0;
  endtask

  task automatic send_frame(input int n, input logic [11:0] first);
    for (int i = 0; i < n; i++) send(first + 12'(i), i == n - 1);
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    tests++; if (tready !== 1'b0) begin fails++; $display("FAIL rst_tready: got %0b exp 0", tready); end
    tests++; if (cv !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b exp 0", cv); end
    tests++; if (cu !== 1'b0 || le !== 1'b0) begin fails++; $display("FAIL rst_pulses: upd=%0b err=%0b exp 0", cu, le); end
    tests++; if (flat !== '0) begin fails++; $display("FAIL rst_flat: got %h exp 0", flat); end
    rst = 0;
    @(negedge clk);
    tests++; if (tready !== 1'b1) begin fails++; $display("FAIL idle_tready: got %0b exp 1", tready); end
  endtask

  task automatic test_good_frame;
    swap = 1;
    send_frame(16, 12'h001);
    tests++; if (tready !== 1'b0) begin fails++; $display("FAIL pend_tready: got %0b exp 0", tready); end
    @(negedge clk);
    tests++; if (cu !== 1'b1) begin fails++; $display("FAIL good_update: got %0b exp 1", cu); end
    tests++; if (tap(0) !== 12'h001 || tap(15) !== 12'h010) begin fails++; $display("FAIL good_taps: tap0=%h tap15=%h exp 001 010", tap(0), tap(15)); end
    tests++; if (cv !== 1'b1) begin fails++; $display("FAIL good_valid: got %0b exp 1", cv); end
    @(negedge clk);
    tests++; if (cu !== 1'b0 || tready !== 1'b1) begin fails++; $display("FAIL good_after: upd=%0b tready=%0b exp 0 1", cu, tready); end
  endtask

  task automatic test_short_frame;
    int e0 = n_err, u0 = n_upd;
    send_frame(10, 12'h0A0);
    tests++; if (le !== 1'b1) begin fails++; $display("FAIL short_err: got %0b exp 1", le); end
    @(negedge clk);
    tests++; if (n_err !== e0 + 1 || n_upd !== u0) begin fails++; $display("FAIL short_counts: err=%0d upd=%0d exp %0d %0d", n_err - e0, n_upd - u0, 1, 0); end
    tests++; if (tap(0) !== 12'h001 || tap(9) !== 12'h00A || cv !== 1'b1) begin fails++; $display("FAIL short_keep: tap0=%h tap9=%h valid=%0b exp 001 00a 1", tap(0), tap(9), cv); end
    send(12'h003, 1'b1);
    tests++; if (le !== 1'b1) begin fails++; $display("FAIL oneword_err: got %0b exp 1", le); end
    @(negedge clk);
    tests++; if (le !== 1'b0 || n_upd !== u0) begin fails++; $display("FAIL oneword_after: err=%0b upd=%0d exp 0 0", le, n_upd - u0); end
  endtask

  task automatic test_long_frame;
    int e0 = n_err, u0 = n_upd;
    accepted = 0;
    for (int i = 0; i < 19; i++) send(12'h400 + 12'(i), 1'b0);
    tests++; if (le !== 1'b0 || n_err !== e0) begin fails++; $display("FAIL long_early_err: err=%0b cnt=%0d exp 0 0", le, n_err - e0); end
    send(12'h413, 1'b1);
    tests++; if (le !== 1'b1) begin fails++; $display("FAIL long_err: got %0b exp 1", le); end
    tests++; if (accepted !== 20) begin fails++; $display("FAIL long_accepted: got %0d exp 20", accepted); end
    @(negedge clk);
    tests++; if (n_err !== e0 + 1 || n_upd !== u0) begin fails++; $display("FAIL long_counts: err=%0d upd=%0d exp 1 0", n_err - e0, n_upd - u0); end
    tests++; if (tap(0) !== 12'h001 || tap(15) !== 12'h010) begin fails++; $display("FAIL long_keep: tap0=%h tap15=%h exp 001 010", tap(0), tap(15)); end
  endtask

  task automatic test_stall;
    int bad = 0;
    swap = 0;
    send_frame(16, 12'h200);
    tv = 1; td = 12'h555; tl = 0;
    for (int k = 0; k < 8; k++) begin
      if (tready !== 1'b0 || cu !== 1'b0) bad++;
      @(negedge clk);
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL stall_tready: bad_cycles=%0d exp 0", bad); end
    tests++; if (tap(0) !== 12'h001) begin fails++; $display("FAIL stall_early: tap0=%h exp 001", tap(0)); end
    swap = 1;
    @(negedge clk);
    tv = 0;
    tests++; if (cu !== 1'b1) begin fails++; $display("FAIL stall_update: got %0b exp 1", cu); end
    tests++; if (tap(0) !== 12'h200 || tap(15) !== 12'h20F) begin fails++; $display("FAIL stall_taps: tap0=%h tap15=%h exp 200 20f", tap(0), tap(15)); end
    @(negedge clk);
  endtask

  task automatic test_sign;
    swap = 1;
    for (int i = 0; i < 16; i++) begin
      send(i % 2 == 0 ? 12'h800 : 12'h7FF, i == 15);
      if (i != 15) repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    tests++; if (cu !== 1'b1) begin fails++; $display("FAIL sign_update: got %0b exp 1", cu); end
    tests++; if ($signed(tap(0)) !== -12'sd2048) begin fails++; $display("FAIL sign_tap0: got %0d exp -2048", $signed(tap(0))); end
    tests++; if ($signed(tap(1)) !== 12'sd2047) begin fails++; $display("FAIL sign_tap1: got %0d exp 2047", $signed(tap(1))); end
    tests++; if (tap(14) !== 12'h800 || tap(15) !== 12'h7FF) begin fails++; $display("FAIL sign_tail: tap14=%h tap15=%h exp 800 7ff", tap(14), tap(15)); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 8; i++) send(12'h0F0 + 12'(i), 1'b0);
    tv = 1; td = 12'h0F8; rst = 1;
    @(negedge clk);
    tests++; if (tready !== 1'b0 || cu !== 1'b0) begin fails++; $display("FAIL mid_rst_out: tready=%0b upd=%0b exp 0 0", tready, cu); end
    tests++; if (flat !== '0 || cv !== 1'b0) begin fails++; $display("FAIL mid_rst_bank: flat=%h valid=%0b exp 0 0", flat, cv); end
    rst = 0; tv = 0;
    @(negedge clk);
    tests++; if (tready !== 1'b1 || flat !== '0) begin fails++; $display("FAIL mid_post: tready=%0b flat=%h exp 1 0", tready, flat); end
    swap = 1;
    send_frame(16, 12'h300);
    @(negedge clk);
    tests++; if (cu !== 1'b1 || cv !== 1'b1) begin fails++; $display("FAIL b_update: upd=%0b valid=%0b exp 1 1", cu, cv); end
    tests++; if (tap(0) !== 12'h300 || tap(8) !== 12'h308 || tap(15) !== 12'h30F) begin fails++; $display("FAIL b_taps: tap0=%h tap8=%h tap15=%h exp 300 308 30f", tap(0), tap(8), tap(15)); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_good_frame;
    test_short_frame;
    test_long_frame;
    test_stall;
    test_sign;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
